// File: rtl/dot_product_seq.sv
// rtl/dot_product_seq.sv - signed dot-product sequencer feeding an iterative 8x8 multiplier
//
// Accepts signed 8-bit operand pairs on a valid/ready stream, issues each pair to
// an external iterative multiplier, accumulates the signed 16-bit products and
// reports one result per vector (vector end marked by in_last).
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   in_valid/in_ready operand pair handshake (ready only in IDLE)
//   in_a, in_b        signed operands
//   in_last           pair closes its vector
//   mul_start         one-cycle start pulse to the multiplier
//   mul_a, mul_b      operands to the multiplier, stable while mul_start is high
//   mul_product       signed product from the multiplier
//   mul_ready         multiplier result valid
//   acc_out           signed result of the last completed vector (held)
//   acc_valid         one-cycle pulse when the result outputs update
//   acc_len           number of pairs accumulated into acc_out (wraps at 256)
//   acc_ovf           signed overflow happened in that vector
//   acc_err           vector aborted by multiplier timeout

module dot_product_seq #(
    parameter int ACC_W   = 24,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic             mul_start,
    output logic [7:0]       mul_a,
    output logic [7:0]       mul_b,
    input  logic [15:0]      mul_product,
    input  logic             mul_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    output logic [7:0]       acc_len,
    output logic             acc_ovf,
    output logic             acc_err
);

    // The counter must be able to hold both TIMEOUT and the ignore threshold of 2.
    localparam int CNT_W = (TIMEOUT < 3) ? 2 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACCUM,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         op_a_q, op_a_d;
    logic [7:0]         op_b_q, op_b_d;
    logic               last_q, last_d;
    logic               mul_start_q, mul_start_d;
    logic [7:0]         mul_a_q, mul_a_d;
    logic [7:0]         mul_b_q, mul_b_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [15:0]        prod_q, prod_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [7:0]         len_q, len_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;
    logic [ACC_W-1:0]   acc_out_q, acc_out_d;
    logic               acc_valid_q, acc_valid_d;
    logic [7:0]         acc_len_q, acc_len_d;
    logic               acc_ovf_q, acc_ovf_d;
    logic               acc_err_q, acc_err_d;

    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   acc_sum;
    logic               sum_ovf;

    // Product sign-extended to the accumulator width; the sum wraps naturally.
    assign prod_ext = {{(ACC_W-16){prod_q[15]}}, prod_q};
    assign acc_sum  = acc_q + prod_ext;
    // Overflow: addends agree in sign but the wrapped sum does not.
    assign sum_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        last_d      = last_q;
        mul_start_d = 1'b0;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        wait_cnt_d  = wait_cnt_q;
        prod_d      = prod_q;
        acc_d       = acc_q;
        len_d       = len_q;
        ovf_d       = ovf_q;
        err_d       = err_q;
        acc_out_d   = acc_out_q;
        acc_valid_d = 1'b0;
        acc_len_d   = acc_len_q;
        acc_ovf_d   = acc_ovf_q;
        acc_err_d   = acc_err_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_a_d  = in_a;
                    op_b_d  = in_b;
                    last_d  = in_last;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mul_start_d = 1'b1;
                mul_a_d     = op_a_q;
                mul_b_d     = op_b_q;
                wait_cnt_d  = '0;
                state_d     = WAIT;
            end
            WAIT: begin
                // The first two WAIT edges see the multiplier's capture edge and
                // possibly a ready left over from the previous product.
                if ((wait_cnt_q >= CNT_W'(2)) && mul_ready) begin
                    prod_d  = mul_product;
                    state_d = ACCUM;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ACCUM: begin
                acc_d = acc_sum;
                len_d = len_q + 8'd1;
                if (sum_ovf) begin
                    ovf_d = 1'b1;
                end
                state_d = last_q ? DONE : IDLE;
            end
            DONE: begin
                acc_out_d   = acc_q;
                acc_len_d   = len_q;
                acc_ovf_d   = ovf_q;
                acc_err_d   = err_q;
                acc_valid_d = 1'b1;
                acc_d       = '0;
                len_d       = '0;
                ovf_d       = 1'b0;
                err_d       = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            last_q      <= 1'b0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            wait_cnt_q  <= '0;
            prod_q      <= '0;
            acc_q       <= '0;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            acc_out_q   <= '0;
            acc_valid_q <= 1'b0;
            acc_len_q   <= '0;
            acc_ovf_q   <= 1'b0;
            acc_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            last_q      <= last_d;
            mul_start_q <= mul_start_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            wait_cnt_q  <= wait_cnt_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            len_q       <= len_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
            acc_out_q   <= acc_out_d;
            acc_valid_q <= acc_valid_d;
            acc_len_q   <= acc_len_d;
            acc_ovf_q   <= acc_ovf_d;
            acc_err_q   <= acc_err_d;
        end
    end

    // Ready is gated by rst so nothing appears acceptable while reset is held.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign acc_out   = acc_out_q;
    assign acc_valid = acc_valid_q;
    assign acc_len   = acc_len_q;
    assign acc_ovf   = acc_ovf_q;
    assign acc_err   = acc_err_q;

endmodule

// File: tb/tb_dot_product_seq.sv
// tb/tb_dot_product_seq.sv - self-checking bench for dot_product_seq

module tb_dot_product_seq;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic signed [7:0]  in_a, in_b;
    logic               in_last;
    logic               in_ready, in_ready17;
    logic               mul_start, mul_start17;
    logic signed [7:0]  mul_a, mul_b;
    logic [7:0]         mul_a17, mul_b17;
    logic [15:0]        mul_product;
    logic               mul_ready;
    logic [23:0]        acc_out;
    logic [16:0]        acc_out17;
    logic               acc_valid, acc_valid17;
    logic [7:0]         acc_len, acc_len17;
    logic               acc_ovf, acc_ovf17;
    logic               acc_err, acc_err17;

    always #5 clk = ~clk;

    dot_product_seq #(.ACC_W(24), .TIMEOUT(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_product(mul_product), .mul_ready(mul_ready),
        .acc_out(acc_out), .acc_valid(acc_valid), .acc_len(acc_len),
        .acc_ovf(acc_ovf), .acc_err(acc_err)
    );

    dot_product_seq #(.ACC_W(17), .TIMEOUT(32)) dut17 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready17),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mul_start(mul_start17), .mul_a(mul_a17), .mul_b(mul_b17),
        .mul_product(mul_product), .mul_ready(mul_ready),
        .acc_out(acc_out17), .acc_valid(acc_valid17), .acc_len(acc_len17),
        .acc_ovf(acc_ovf17), .acc_err(acc_err17)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic longint wrapw(input longint x, input int w);
        longint m;
        m = x & ((64'sd1 <<< w) - 1);
        if (m >= (64'sd1 <<< (w - 1))) m = m - (64'sd1 <<< w);
        return m;
    endfunction

    typedef struct {
        longint acc24;
        longint acc17;
        int     len;
        bit     ovf24;
        bit     ovf17;
        bit     err;
    } res_t;

    res_t   exp_q[$];
    logic [15:0] iss_q[$];

    // Reference model state: running vector sums at both widths.
    longint v24 = 0, v17 = 0;
    int     vlen = 0;
    bit     vovf24 = 0, vovf17 = 0;
    bit     dead = 0;
    int     lat = 2;
    int     cyc = 0, accept_cyc = 0, valid_cyc = 0;
    int     acc_cnt = 0, res_seen = 0, start_cnt = 0;
    logic   prev_start = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            v24 <= 0; v17 <= 0; vlen <= 0; vovf24 <= 0; vovf17 <= 0;
            exp_q.delete();
            iss_q.delete();
        end else if (in_valid && in_ready) begin
            automatic longint p   = longint'(in_a) * longint'(in_b);
            automatic longint s24 = v24 + p;
            automatic longint s17 = v17 + p;
            automatic res_t   r;
            acc_cnt    <= acc_cnt + 1;
            accept_cyc <= cyc;
            iss_q.push_back({in_a, in_b});
            if (dead) begin
                r = '{v24, v17, vlen, vovf24, vovf17, 1'b1};
                exp_q.push_back(r);
                v24 <= 0; v17 <= 0; vlen <= 0; vovf24 <= 0; vovf17 <= 0;
            end else begin
                r.acc24 = wrapw(s24, 24);
                r.acc17 = wrapw(s17, 17);
                r.len   = (vlen + 1) % 256;
                r.ovf24 = vovf24 || (r.acc24 != s24);
                r.ovf17 = vovf17 || (r.acc17 != s17);
                r.err   = 1'b0;
                if (in_last) begin
                    exp_q.push_back(r);
                    v24 <= 0; v17 <= 0; vlen <= 0; vovf24 <= 0; vovf17 <= 0;
                end else begin
                    v24 <= r.acc24; v17 <= r.acc17; vlen <= r.len;
                    vovf24 <= r.ovf24; vovf17 <= r.ovf17;
                end
            end
        end
    end

    // Per-cycle comparison against the reference model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("mirror_start", mul_start17, mul_start);
            chk("mirror_valid", acc_valid17, acc_valid);
            chk("mirror_ready", in_ready17, in_ready);
            if (mul_start) begin
                automatic logic [15:0] ab;
                chk("ready_low_issue", in_ready, 0);
                chk("start_single_cycle", prev_start, 0);
                chk("start_latency", cyc - accept_cyc, 2);
                if (iss_q.size() == 0) begin
                    chk("start_unexpected", 1, 0);
                end else begin
                    ab = iss_q.pop_front();
                    chk("mul_a", mul_a, $signed(ab[15:8]));
                    chk("mul_b", mul_b, $signed(ab[7:0]));
                end
                start_cnt <= start_cnt + 1;
            end
            if (acc_valid) begin
                valid_cyc <= cyc;
                res_seen  <= res_seen + 1;
                if (exp_q.size() == 0) begin
                    chk("valid_unexpected", 1, 0);
                end else begin
                    automatic res_t r = exp_q.pop_front();
                    chk("acc_out", $signed(acc_out), r.acc24);
                    chk("acc_out17", $signed(acc_out17), r.acc17);
                    chk("acc_len", acc_len, r.len);
                    chk("acc_len17", acc_len17, r.len);
                    chk("acc_ovf", acc_ovf, r.ovf24);
                    chk("acc_ovf17", acc_ovf17, r.ovf17);
                    chk("acc_err", acc_err, r.err);
                    chk("acc_err17", acc_err17, r.err);
                end
            end
        end
        prev_start <= mul_start;
    end

    // Multiplier model: captures on the edge after mul_start, leaves the previous
    // ready/product visible for two edges, then presents the product after lat.
    logic signed [15:0] mop;
    bit  mbusy = 0;
    int  mk = 0;
    initial begin
        mul_ready   = 1'b0;
        mul_product = 16'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mul_ready = 1'b0;
                mbusy     = 0;
            end else if (mul_start) begin
                mbusy = 1;
                mk    = 0;
                mop   = mul_a * mul_b;
            end else if (mbusy) begin
                mk++;
                if (mk == lat && !dead) begin
                    mul_ready   = 1'b1;
                    mul_product = mop;
                    mbusy       = 0;
                end else if (mk == 2) begin
                    mul_ready = 1'b0;
                    if (dead) mbusy = 0;
                end
            end
        end
    end

    task automatic send(input int a, input int b, input bit last);
        int n0;
        bit ok;
        n0 = acc_cnt;
        ok = 0;
        in_valid = 1'b1;
        in_a = 8'(a);
        in_b = 8'(b);
        in_last = last;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (acc_cnt != n0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("send_timeout", ok, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_result();
        int n0;
        bit ok;
        n0 = res_seen;
        ok = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (res_seen != n0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("result_timeout", ok, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_acc_out"}, acc_out, 0);
        chk({tag, "_acc_valid"}, acc_valid, 0);
        chk({tag, "_acc_len"}, acc_len, 0);
        chk({tag, "_acc_ovf"}, acc_ovf, 0);
        chk({tag, "_acc_err"}, acc_err, 0);
        chk({tag, "_mul_start"}, mul_start, 0);
        chk({tag, "_mul_a"}, mul_a, 0);
        chk({tag, "_mul_b"}, mul_b, 0);
    endtask

    int s0;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = 8'sd0;
        in_b = 8'sd0;
        in_last = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst0");
        chk("rst0_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", in_ready, 1);
        @(negedge clk);

        // Single pair at minimum multiplier latency.
        lat = 2;
        s0 = start_cnt;
        send(3, -4, 1);
        wait_result();
        chk("t1_acc_out", $signed(acc_out), -12);
        chk("t1_len", acc_len, 1);
        chk("t1_latency", valid_cyc - accept_cyc, 7);
        chk("t1_starts", start_cnt - s0, 1);

        // Three-pair vector at the operand extremes, slower multiplier.
        lat = 5;
        s0 = res_seen;
        send(127, 127, 0);
        send(-128, -128, 0);
        send(-128, 127, 1);
        wait_result();
        chk("t2_acc_out", $signed(acc_out), 16257);
        chk("t2_len", acc_len, 3);
        chk("t2_latency", valid_cyc - accept_cyc, 10);
        repeat (4) @(negedge clk);
        chk("t2_one_valid", res_seen - s0, 1);

        // in_valid held high across five back-to-back pairs.
        lat = 3;
        s0 = start_cnt;
        for (int i = 1; i <= 5; i++) send(i, 2 * i, i == 5);
        wait_result();
        chk("t3_acc_out", $signed(acc_out), 110);
        chk("t3_len", acc_len, 5);
        chk("t3_starts", start_cnt - s0, 5);

        // Overflow at 17 bits, none at 24 bits.
        lat = 2;
        for (int i = 1; i <= 4; i++) send(-128, -128, i == 4);
        wait_result();
        chk("t4_acc_out17", $signed(acc_out17), -65536);
        chk("t4_ovf17", acc_ovf17, 1);
        chk("t4_acc_out24", $signed(acc_out), 65536);
        chk("t4_ovf24", acc_ovf, 0);

        // Dead multiplier: timeout abort, then recovery.
        dead = 1;
        send(9, 9, 1);
        wait_result();
        chk("t5_err", acc_err, 1);
        chk("t5_len", acc_len, 0);
        chk("t5_acc_out", $signed(acc_out), 0);
        dead = 0;
        send(2, 5, 1);
        wait_result();
        chk("t5_acc_out2", $signed(acc_out), 10);
        chk("t5_err2", acc_err, 0);

        // Reset pulse in the middle of WAIT of a two-pair vector.
        send(3, 3, 0);
        send(4, 4, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_in_ready_rst", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset_outputs("t6");
        chk("t6_in_ready", in_ready, 1);
        @(negedge clk);
        send(7, 7, 1);
        wait_result();
        chk("t6_acc_out", $signed(acc_out), 49);
        chk("t6_len", acc_len, 1);

        repeat (50) @(negedge clk);
        chk("drain_exp", exp_q.size(), 0);
        chk("drain_iss", iss_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
